// File: rtl/bank_rd_pkg.sv
// Shared widths, requester indices and the address-to-bank helper for the scratchpad
// read scheduler.
package bank_rd_pkg;

  localparam int unsigned BANKBITS = 5;
  localparam int unsigned WORDBITS = 9;
  localparam int unsigned DATABITS = 32;
  localparam int unsigned A        = BANKBITS + WORDBITS;

  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;
  localparam int unsigned REQ_C = 2;
  localparam int unsigned NREQ  = 3;

  typedef logic [A-1:0]        addr_t;
  typedef logic [BANKBITS-1:0] bank_t;
  typedef logic [DATABITS-1:0] data_t;

  function automatic bank_t bank_of(input addr_t addr);
    return addr[WORDBITS +: BANKBITS];
  endfunction

endpackage

// File: rtl/bank_rd_sched_if.sv
// Requester handshakes and the three memory lanes of the scratchpad read scheduler.
// slave = scheduler side, master = requesters plus memory.
interface bank_rd_sched_if;
  import bank_rd_pkg::*;

  logic                       i_req_valid, d_req_valid, c_req_valid;
  addr_t                      i_req_addr, d_req_addr, c_req_addr;
  logic                       i_req_ready, d_req_ready, c_req_ready;
  logic                       i_rsp_valid, d_rsp_valid, c_rsp_valid;
  data_t                      i_rsp_data, d_rsp_data, c_rsp_data;
  logic [NREQ-1:0]            m_en;
  logic [NREQ*A-1:0]          m_addr;
  logic [NREQ*DATABITS-1:0]   m_rdata;

  modport slave (
    input  i_req_valid, d_req_valid, c_req_valid,
    input  i_req_addr, d_req_addr, c_req_addr,
    output i_req_ready, d_req_ready, c_req_ready,
    output i_rsp_valid, d_rsp_valid, c_rsp_valid,
    output i_rsp_data, d_rsp_data, c_rsp_data,
    output m_en, m_addr,
    input  m_rdata
  );

  modport master (
    output i_req_valid, d_req_valid, c_req_valid,
    output i_req_addr, d_req_addr, c_req_addr,
    input  i_req_ready, d_req_ready, c_req_ready,
    input  i_rsp_valid, d_rsp_valid, c_rsp_valid,
    input  i_rsp_data, d_rsp_data, c_rsp_data,
    input  m_en, m_addr,
    output m_rdata
  );

endinterface

// File: rtl/bank_rd_arb.sv
// Combinational bank arbiter: a held request is granted unless a higher-ranked held request
// targets the same bank. Starved requesters outrank non-starved ones; ties go i > d > c.
module bank_rd_arb
  import bank_rd_pkg::*;
(
  input  logic  [NREQ-1:0] hold_v_i,
  input  bank_t [NREQ-1:0] bank_i,
  input  logic  [NREQ-1:0] starved_i,
  output logic  [NREQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    for (int r = 0; r < NREQ; r++) begin
      grant_o[r] = hold_v_i[r];
      for (int j = 0; j < NREQ; j++) begin
        if (j != r && hold_v_i[j] && (bank_i[j] == bank_i[r]) &&
            ((starved_i[j] && !starved_i[r]) || ((starved_i[j] == starved_i[r]) && (j < r)))) begin
          grant_o[r] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bank_rd_sched.sv
// Three-requester banked read scheduler: hold registers, starvation counters, return pipes.
// Build option: define BANK_RD_SCHED_STARVE_EN for starvation counters and priority boost.
module bank_rd_sched
  import bank_rd_pkg::*;
#(
  parameter int unsigned RDLAT  = 2,
  parameter int unsigned STARVE = 7
) (
  input logic            clk,
  input logic            rst,
  bank_rd_sched_if.slave bus
);

  if (RDLAT < 1 || RDLAT > 4) begin : g_bad_rdlat
    $error("RDLAT must be 1..4");
  end
  if (STARVE < 1 || STARVE > 15) begin : g_bad_starve
    $error("STARVE must be 1..15");
  end

  logic  [NREQ-1:0] req_valid, req_ready, accept, grant, starved;
  logic  [NREQ-1:0] hold_v_q, hold_v_d;
  addr_t [NREQ-1:0] req_addr, hold_addr_q, hold_addr_d;
  bank_t [NREQ-1:0] bank;
  logic  [NREQ-1:0] pipe_q [RDLAT];
  logic  [NREQ-1:0] pipe_d [RDLAT];

  always_comb begin
    req_valid = {bus.c_req_valid, bus.d_req_valid, bus.i_req_valid};
    req_addr  = '0;
    req_addr[REQ_I] = bus.i_req_addr;
    req_addr[REQ_D] = bus.d_req_addr;
    req_addr[REQ_C] = bus.c_req_addr;
    for (int r = 0; r < NREQ; r++) bank[r] = bank_of(hold_addr_q[r]);
  end

  bank_rd_arb u_arb (
    .hold_v_i  (hold_v_q),
    .bank_i    (bank),
    .starved_i (starved),
    .grant_o   (grant)
  );

  // Ready only looks at the hold state, so there is no path from req_valid to req_ready.
  always_comb begin
    req_ready = ~hold_v_q | grant;
    accept    = req_valid & req_ready;
    for (int r = 0; r < NREQ; r++) begin
      hold_v_d[r]    = accept[r] ? 1'b1 : (grant[r] ? 1'b0 : hold_v_q[r]);
      hold_addr_d[r] = accept[r] ? req_addr[r] : hold_addr_q[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q    <= '0;
      hold_addr_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
    end
  end

`ifdef BANK_RD_SCHED_STARVE_EN
  localparam int unsigned   CntW    = $clog2(STARVE + 1);
  localparam logic [CntW-1:0] StarveC = CntW'(STARVE);

  logic [NREQ-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      starved[r] = (cnt_q[r] == StarveC);
      if (!hold_v_q[r] || grant[r]) cnt_d[r] = '0;
      else if (!starved[r])         cnt_d[r] = cnt_q[r] + 1'b1;
      else                          cnt_d[r] = cnt_q[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  always_comb starved = '0;
`endif

  always_comb begin
    pipe_d[0] = grant;
    for (int k = 1; k < RDLAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RDLAT; k++) pipe_q[k] <= '0;
    end else begin
      for (int k = 0; k < RDLAT; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  always_comb begin
    bus.m_en   = grant;
    bus.m_addr = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant[r]) bus.m_addr[r*A +: A] = hold_addr_q[r];
    end
    bus.i_req_ready = req_ready[REQ_I];
    bus.d_req_ready = req_ready[REQ_D];
    bus.c_req_ready = req_ready[REQ_C];
    bus.i_rsp_valid = pipe_q[RDLAT-1][REQ_I];
    bus.d_rsp_valid = pipe_q[RDLAT-1][REQ_D];
    bus.c_rsp_valid = pipe_q[RDLAT-1][REQ_C];
    bus.i_rsp_data  = bus.m_rdata[REQ_I*DATABITS +: DATABITS];
    bus.d_rsp_data  = bus.m_rdata[REQ_D*DATABITS +: DATABITS];
    bus.c_rsp_data  = bus.m_rdata[REQ_C*DATABITS +: DATABITS];
  end

endmodule

// File: tb/tb_bank_rd_sched.sv
// Directed bench for bank_rd_sched; the starvation scenario follows BANK_RD_SCHED_STARVE_EN.
module tb_bank_rd_sched;
  import bank_rd_pkg::*;

  localparam int unsigned RDLAT  = 2;
  localparam int unsigned STARVE = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_rd_sched_if bus ();

  bank_rd_sched #(.RDLAT(RDLAT), .STARVE(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic data_t mem(input addr_t a);
    return 32'hC0DE_0000 | {18'h0, a};
  endfunction

  // Memory model: lane addresses delayed RDLAT edges, then looked up.
  logic [NREQ*A-1:0] apipe [RDLAT];
  always @(posedge clk) begin
    apipe[0] <= bus.m_addr;
    for (int k = 1; k < RDLAT; k++) apipe[k] <= apipe[k-1];
  end

  logic [NREQ*DATABITS-1:0] rd;
  always_comb begin
    rd = '0;
    for (int k = 0; k < NREQ; k++) rd[k*DATABITS +: DATABITS] = mem(apipe[RDLAT-1][k*A +: A]);
    bus.m_rdata = rd;
  end

  logic [2:0] rdy, rspv;
  assign rdy  = {bus.c_req_ready, bus.d_req_ready, bus.i_req_ready};
  assign rspv = {bus.c_rsp_valid, bus.d_rsp_valid, bus.i_rsp_valid};

  task automatic idle();
    bus.i_req_valid = 1'b0; bus.d_req_valid = 1'b0; bus.c_req_valid = 1'b0;
    bus.i_req_addr  = '0;   bus.d_req_addr  = '0;   bus.c_req_addr  = '0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.m_en !== 3'b000) begin bad++; $display("FAIL reset_m_en got=%b exp=000", bus.m_en); end
    total++; if (rspv !== 3'b000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=000", rspv); end
    total++; if (rdy !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", rdy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_parallel();
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 14'h0005;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 14'h0205;
    bus.c_req_valid = 1'b1; bus.c_req_addr = 14'h0405;
    total++; if (rdy !== 3'b111) begin bad++; $display("FAIL par_ready got=%b exp=111", rdy); end
    @(negedge clk); idle();
    total++; if (bus.m_en !== 3'b111) begin bad++; $display("FAIL par_m_en got=%b exp=111", bus.m_en); end
    total++;
    if (bus.m_addr !== {14'h0405, 14'h0205, 14'h0005}) begin
      bad++; $display("FAIL par_m_addr got=%h exp=%h", bus.m_addr, {14'h0405, 14'h0205, 14'h0005});
    end
    @(negedge clk);
    total++; if (rspv !== 3'b000) begin bad++; $display("FAIL par_rsp_early got=%b exp=000", rspv); end
    @(negedge clk);
    total++; if (rspv !== 3'b111) begin bad++; $display("FAIL par_rsp_valid got=%b exp=111", rspv); end
    total++; if (bus.i_rsp_data !== mem(14'h0005)) begin bad++; $display("FAIL par_i_data got=%h exp=%h", bus.i_rsp_data, mem(14'h0005)); end
    total++; if (bus.d_rsp_data !== mem(14'h0205)) begin bad++; $display("FAIL par_d_data got=%h exp=%h", bus.d_rsp_data, mem(14'h0205)); end
    total++; if (bus.c_rsp_data !== mem(14'h0405)) begin bad++; $display("FAIL par_c_data got=%h exp=%h", bus.c_rsp_data, mem(14'h0405)); end
    @(negedge clk);
    total++; if (rspv !== 3'b000) begin bad++; $display("FAIL par_rsp_after got=%b exp=000", rspv); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 14'h0600;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 14'h0601;
    @(negedge clk); idle();
    total++; if (bus.m_en !== 3'b001) begin bad++; $display("FAIL cf_m_en1 got=%b exp=001", bus.m_en); end
    total++; if (rdy[1:0] !== 2'b01) begin bad++; $display("FAIL cf_ready got=%b exp=01", rdy[1:0]); end
    total++;
    if (bus.m_addr !== {14'h0, 14'h0, 14'h0600}) begin
      bad++; $display("FAIL cf_m_addr1 got=%h exp=%h", bus.m_addr, {14'h0, 14'h0, 14'h0600});
    end
    @(negedge clk);
    total++; if (bus.m_en !== 3'b010) begin bad++; $display("FAIL cf_m_en2 got=%b exp=010", bus.m_en); end
    total++; if (bus.m_addr[A +: A] !== 14'h0601) begin bad++; $display("FAIL cf_m_addr2 got=%h exp=0601", bus.m_addr[A +: A]); end
    @(negedge clk);
    total++; if (rspv !== 3'b001) begin bad++; $display("FAIL cf_rsp_i got=%b exp=001", rspv); end
    total++; if (bus.i_rsp_data !== mem(14'h0600)) begin bad++; $display("FAIL cf_i_data got=%h exp=%h", bus.i_rsp_data, mem(14'h0600)); end
    @(negedge clk);
    total++; if (rspv !== 3'b010) begin bad++; $display("FAIL cf_rsp_d got=%b exp=010", rspv); end
    total++; if (bus.d_rsp_data !== mem(14'h0601)) begin bad++; $display("FAIL cf_d_data got=%h exp=%h", bus.d_rsp_data, mem(14'h0601)); end
    @(negedge clk);
  endtask

  // i hammers bank 1 from the first edge, c parks one bank-1 read, d joins one edge later.
  task automatic test_starve();
    int c_grants;
    int i_grants;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 14'h0200;
    bus.c_req_valid = 1'b1; bus.c_req_addr = 14'h0280;
`ifdef BANK_RD_SCHED_STARVE_EN
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        total++; if (bus.m_en !== 3'b001) begin bad++; $display("FAIL sv_m_en_c%0d got=%b exp=001", k, bus.m_en); end
      end else if (k == 8) begin
        total++; if (bus.m_en !== 3'b100) begin bad++; $display("FAIL sv_c_boost got=%b exp=100", bus.m_en); end
        total++; if (bus.m_addr[2*A +: A] !== 14'h0280) begin bad++; $display("FAIL sv_c_addr got=%h exp=0280", bus.m_addr[2*A +: A]); end
        total++; if (bus.i_req_ready !== 1'b0) begin bad++; $display("FAIL sv_i_denied got=%b exp=0", bus.i_req_ready); end
      end else begin
        total++; if (bus.m_en !== 3'b010) begin bad++; $display("FAIL sv_d_boost got=%b exp=010", bus.m_en); end
      end
      bus.c_req_valid = 1'b0;
      bus.i_req_addr  = 14'(14'h0200 + k);
      bus.d_req_valid = 1'b1; bus.d_req_addr = 14'(14'h0300 + k);
    end
    c_grants = 0; i_grants = 0;
`else
    c_grants = 0; i_grants = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.m_en[2]) c_grants++;
      if (bus.m_en[0]) i_grants++;
      bus.c_req_valid = 1'b0;
      bus.i_req_addr  = 14'(14'h0200 + k);
      bus.d_req_valid = 1'b1; bus.d_req_addr = 14'(14'h0300 + k);
    end
    total++; if (c_grants !== 0) begin bad++; $display("FAIL sv_c_starved got=%0d exp=0", c_grants); end
    total++; if (i_grants !== 100) begin bad++; $display("FAIL sv_i_grants got=%0d exp=100", i_grants); end
`endif
    idle();
    for (int k = 0; k < 10; k++) @(negedge clk);
    total++; if (rdy !== 3'b111) begin bad++; $display("FAIL sv_drained got=%b exp=111", rdy); end
  endtask

  task automatic test_back_to_back();
    addr_t a;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= 8) begin
        a = addr_t'((n - 1) * 512 + (n - 1));
        total++; if (bus.m_en !== 3'b001) begin bad++; $display("FAIL b2b_m_en%0d got=%b exp=001", n, bus.m_en); end
        total++; if (bus.m_addr[A-1:0] !== a) begin bad++; $display("FAIL b2b_addr%0d got=%h exp=%h", n, bus.m_addr[A-1:0], a); end
      end
      if (n >= 3) begin
        a = addr_t'((n - 3) * 512 + (n - 3));
        total++; if (rspv !== 3'b001) begin bad++; $display("FAIL b2b_rsp%0d got=%b exp=001", n, rspv); end
        total++; if (bus.i_rsp_data !== mem(a)) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", n, bus.i_rsp_data, mem(a)); end
      end
      if (n < 8) begin
        total++; if (bus.i_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", n, bus.i_req_ready); end
        bus.i_req_valid = 1'b1; bus.i_req_addr = addr_t'(n * 512 + n);
      end else begin
        idle();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int stray;
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 14'h0010;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 14'h0210;
    bus.c_req_valid = 1'b1; bus.c_req_addr = 14'h0020;
    @(negedge clk); idle();
    total++; if (bus.m_en !== 3'b011) begin bad++; $display("FAIL rf_m_en got=%b exp=011", bus.m_en); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.m_en !== 3'b000) begin bad++; $display("FAIL rf_m_en_rst got=%b exp=000", bus.m_en); end
    total++; if (rdy !== 3'b111) begin bad++; $display("FAIL rf_ready_rst got=%b exp=111", rdy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rspv !== 3'b000 || bus.m_en !== 3'b000) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rf_no_rsp got=%0d exp=0", stray); end
    bus.i_req_valid = 1'b1; bus.i_req_addr = 14'h0123;
    @(negedge clk); idle();
    total++; if (bus.m_en !== 3'b001) begin bad++; $display("FAIL rf_fresh_m_en got=%b exp=001", bus.m_en); end
    @(negedge clk); @(negedge clk);
    total++; if (rspv !== 3'b001) begin bad++; $display("FAIL rf_fresh_rsp got=%b exp=001", rspv); end
    total++; if (bus.i_rsp_data !== mem(14'h0123)) begin bad++; $display("FAIL rf_fresh_data got=%h exp=%h", bus.i_rsp_data, mem(14'h0123)); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_parallel();
    test_conflict();
    test_starve();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_rd_sched.md
# bank_rd_sched

Three-requester read scheduler for the banked scratchpad: input-stream (i), data-fetch (d) and control (c) ports. Accepts one read per requester through valid/ready, parks it in a one-entry hold register, and issues at most one read per bank per cycle on three per-requester memory lanes. Bank conflicts are resolved by priority with an optional anti-starvation boost. Read data returns on the requester's lane after a fixed memory latency.

## Interface
- BANKBITS, 5, bank-select width; bank = addr[WORDBITS +: BANKBITS]
- WORDBITS, 9, word-within-bank width; A = BANKBITS+WORDBITS
- DATABITS, 32, read data width
- RDLAT, 2, memory read latency in cycles, legal 1..4
- STARVE, 7, consecutive denials before priority boost, legal 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- r_req_valid  in  1  request valid, per r in {i,d,c}
- r_req_addr  in  A  request address
- r_req_ready  out  1  request accepted when valid & ready
- r_rsp_valid  out  1  read data valid; no backpressure
- r_rsp_data  out  DATABITS  read data
- m_en  out  3  lane issue strobes, bit 0=i, 1=d, 2=c
- m_addr  out  3*A  lane addresses, lane k at [k*A +: A]
- m_rdata  in  3*DATABITS  lane read data, valid RDLAT cycles after m_en

## Operation
- Per requester: hold_v, hold_addr, and starvation counter cnt (width $clog2(STARVE+1), saturating).
- Arbitration is combinational from hold registers only; it never depends on r_req_* inputs, so there is no combinational path from request to ready.
- Base priority: i > d > c. With the boost, any requester with cnt == STARVE ranks above all non-starved ones; among starved requesters, i > d > c.
- Grant: a held request is granted unless a higher-ranked held request targets the same bank. Identical addresses also conflict; there is no merging.
- m_en[r] = grant_r; m_addr lane r = hold_addr_r. Non-granted lanes drive address 0.
- r_req_ready = ~hold_v_r | grant_r, which gives back-to-back issue of one read per cycle per requester when conflict-free.
- On valid & ready: hold_v_r <= 1 and hold_addr_r <= r_req_addr. Otherwise, if grant_r: hold_v_r <= 0.
- cnt_r: cleared on grant or when not held; incremented when held and denied; saturates at STARVE.
- Return path: a per-lane RDLAT-deep shift register of m_en. r_rsp_valid = tap RDLAT; r_rsp_data = m_rdata lane r, passed through combinationally.
- Requesters must accept responses in the cycle presented.
- Reset:
  - Clears hold_v, cnt and the return shift registers.
  - In-flight reads are dropped; no r_rsp_valid follows reset.
  - Values out of reset: m_en=0, r_rsp_valid=0, r_req_ready=1.

## Timing
- Request accepted at edge T: held from T. Earliest m_en is the cycle after T; r_rsp_valid follows RDLAT cycles later. Minimum accept-to-response is 1+RDLAT cycles.
- Throughput is one read per requester per cycle when banks differ; 3 reads per cycle aggregate maximum.
- With the boost, a held request waits at most STARVE+2 cycles. Any two starved requesters on the same bank are ordered i > d > c.
- Simultaneous grant and new accept on the same requester: the new address replaces the held one at that edge and hold_v stays 1.
- An rst assertion mid-operation takes effect immediately (asynchronous). The first accept is possible on the first edge after deassertion.
- Responses on different lanes in the same cycle are independent.

## Configuration
- BANK_RD_SCHED_STARVE_EN defined: counters and boost present as above.
- Not defined: counters removed; strict fixed priority i > d > c. c may starve indefinitely under continuous same-bank i/d traffic. STARVE is ignored.

## Structure
- Package bank_rd_pkg holds:
  - REQ_I=0, REQ_D=1, REQ_C=2, NREQ=3
  - function bank_of(addr) returning addr[WORDBITS +: BANKBITS]
- Sub-module bank_rd_arb (purely combinational) takes hold_v[3], bank[3] and starved[3] and produces grant[3]. It is instantiated once.
- Top level holds the hold registers, counters and return shift registers.

## Test plan
- RDLAT=2; i reads 0x0005, d reads 0x0205, c reads 0x0405, all on different banks, accepted at T. Expect m_en=3'b111 the next cycle, and all three r_rsp_valid 2 cycles later with the lane data.
- i and d both on bank 3, accepted together. Expect m_en=3'b001, d_req_ready=0, then m_en=3'b010 the next cycle; d's response arrives one cycle after i's.
- STARVE_EN, STARVE=7; i and d hammer bank 1 every cycle, c holds a bank-1 read. Expect c granted on its 8th held cycle with i and d denied that cycle; c cnt returns to 0.
- Macro undefined, same stimulus. Expect c never granted over 100 cycles.
- Continuous i stream to rotating banks with no conflicts. Expect i_req_ready held at 1 and one m_en[0] per cycle, with responses in order.
- Assert rst with 2 reads in flight and c held. Expect no r_rsp_valid afterwards, m_en=0 and all ready=1. A fresh read after deassertion completes normally.
